// File: rtl/mem_access_stage.sv
// Memory-access stage of the MIPS datapath, between the ALU and register
// writeback. Word loads and stores are serialised over a byte-wide
// synchronous data-memory port, little-endian. ALU results that touch no
// memory are passed straight through to writeback.
module mem_access_stage #(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_memread,
  input  logic              req_memwrite,
  input  logic              req_regwrite,
  input  logic [4:0]        req_wreg,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [4:0]        wb_wreg,
  output logic [31:0]       wb_data,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              regwrite_q, regwrite_d;
  logic [4:0]        wreg_q, wreg_d;
  logic [23:0]       ld_buf_q, ld_buf_d;      // bytes 0..2 of a load; byte 3 goes straight to wb_data
  logic [31:0]       wb_data_q, wb_data_d;
  logic [4:0]        wb_wreg_q, wb_wreg_d;
  logic              wb_regwrite_q, wb_regwrite_d;
  logic              err_q, err_d;

  logic accept;
  logic illegal;
  logic misaligned;

  assign req_ready  = (state_q == IDLE) || (state_q == DONE);
  assign accept     = req_valid && req_ready;
  assign illegal    = req_memread && req_memwrite;
  assign misaligned = CHECK_ALIGN && (req_addr[1:0] != 2'b00) && (req_memread || req_memwrite);

  // Next-state logic: request capture, byte sequencing and writeback update.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    wdata_d       = wdata_q;
    regwrite_d    = regwrite_q;
    wreg_d        = wreg_q;
    ld_buf_d      = ld_buf_q;
    wb_data_d     = wb_data_q;
    wb_wreg_d     = wb_wreg_q;
    wb_regwrite_d = wb_regwrite_q;
    err_d         = err_q;
    unique case (state_q)
      RD: begin
        // Read data lags the strobe by one cycle, so byte n lands at cnt n+1.
        case (cnt_q)
          3'd1:    ld_buf_d[7:0]   = mem_rdata;
          3'd2:    ld_buf_d[15:8]  = mem_rdata;
          3'd3:    ld_buf_d[23:16] = mem_rdata;
          default: ;
        endcase
        if (cnt_q == 3'd4) begin
          state_d       = DONE;
          wb_data_d     = {mem_rdata, ld_buf_q};
          wb_wreg_d     = wreg_q;
          wb_regwrite_d = regwrite_q;
          err_d         = 1'b0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      WR: begin
        if (cnt_q == 3'd3) begin
          state_d       = DONE;
          wb_wreg_d     = wreg_q;
          wb_regwrite_d = 1'b0;
          err_d         = 1'b0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE falls back to IDLE when nothing arrives.
        if (accept) begin
          base_d     = req_addr;
          wdata_d    = req_wdata;
          regwrite_d = req_regwrite;
          wreg_d     = req_wreg;
          cnt_d      = 3'd0;
          if (illegal || misaligned) begin
            state_d       = DONE;
            wb_wreg_d     = req_wreg;
            wb_regwrite_d = 1'b0;
            err_d         = 1'b1;
          end else if (req_memread) begin
            state_d = RD;
          end else if (req_memwrite) begin
            state_d = WR;
          end else begin
            state_d       = DONE;
            wb_data_d     = 32'(req_addr);
            wb_wreg_d     = req_wreg;
            wb_regwrite_d = req_regwrite;
            err_d         = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State register; reset clears everything and drops the strobes at once.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      cnt_q         <= 3'd0;
      base_q        <= '0;
      wdata_q       <= 32'd0;
      regwrite_q    <= 1'b0;
      wreg_q        <= 5'd0;
      ld_buf_q      <= 24'd0;
      wb_data_q     <= 32'd0;
      wb_wreg_q     <= 5'd0;
      wb_regwrite_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      base_q        <= base_d;
      wdata_q       <= wdata_d;
      regwrite_q    <= regwrite_d;
      wreg_q        <= wreg_d;
      ld_buf_q      <= ld_buf_d;
      wb_data_q     <= wb_data_d;
      wb_wreg_q     <= wb_wreg_d;
      wb_regwrite_q <= wb_regwrite_d;
      err_q         <= err_d;
    end
  end

  assign mem_re = (state_q == RD) && !cnt_q[2];
  assign mem_we = (state_q == WR);

  // Memory port drive: address and store byte are zero whenever no strobe is up.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = 8'd0;
    if (mem_re || mem_we) begin
      mem_addr = base_q + ADDR_W'(cnt_q);
    end
    if (mem_we) begin
      case (cnt_q[1:0])
        2'd0:    mem_wdata = wdata_q[7:0];
        2'd1:    mem_wdata = wdata_q[15:8];
        2'd2:    mem_wdata = wdata_q[23:16];
        default: mem_wdata = wdata_q[31:24];
      endcase
    end
  end

  assign wb_valid    = (state_q == DONE);
  assign err         = (state_q == DONE) && err_q;
  assign wb_data     = wb_data_q;
  assign wb_wreg     = wb_wreg_q;
  assign wb_regwrite = wb_regwrite_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed scenarios followed by random
// requests, checked cycle by cycle against a word-level reference model.
module tb_mem_access_stage;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_memread;
  logic        req_memwrite;
  logic        req_regwrite;
  logic [4:0]  req_wreg;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        wb_valid;
  logic        wb_regwrite;
  logic [4:0]  wb_wreg;
  logic [31:0] wb_data;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  logic       fill;
  logic [7:0] dev_mem [0:255];
  logic [7:0] ref_mem [0:255];

  always #5 CLK = ~CLK;

  mem_access_stage dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_memread  (req_memread),
    .req_memwrite (req_memwrite),
    .req_regwrite (req_regwrite),
    .req_wreg     (req_wreg),
    .mem_addr     (mem_addr),
    .mem_re       (mem_re),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .wb_valid     (wb_valid),
    .wb_regwrite  (wb_regwrite),
    .wb_wreg      (wb_wreg),
    .wb_data      (wb_data),
    .err          (err)
  );

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37) + 5);
  endfunction

  // Byte-wide synchronous data memory with one cycle of read latency.
  always @(posedge CLK) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) dev_mem[i] <= init_byte(i);
    end else if (mem_we) begin
      dev_mem[mem_addr[7:0]] <= mem_wdata;
    end
    if (mem_re) mem_rdata <= dev_mem[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_wb_valid", 32'(wb_valid), 32'd0);
      chk("idle_strobes", {30'd0, mem_re, mem_we}, 32'd0);
      chk("idle_ready", 32'(req_ready), 32'd1);
    end
  endtask

  // Issue one request (stage must be ready now) and follow it to its writeback cycle.
  task automatic run_req(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                         input logic wr, input logic rw, input logic [4:0] wreg);
    logic        err_e;
    logic        rw_e;
    int          kind;   // 0 pass-through, 1 load, 2 store, 3 error
    int          lat;
    logic [31:0] data_e;
    err_e  = (rd && wr) || ((rd || wr) && (a[1:0] != 2'b00));
    data_e = a;
    if (err_e) begin
      kind = 3; lat = 1; rw_e = 1'b0;
    end else if (rd) begin
      kind = 1; lat = 6; rw_e = rw;
      for (int b = 0; b < 4; b++) data_e[8*b +: 8] = ref_mem[8'(a + 32'(b))];
    end else if (wr) begin
      kind = 2; lat = 5; rw_e = 1'b0;
      for (int b = 0; b < 4; b++) ref_mem[8'(a + 32'(b))] = wd[8*b +: 8];
    end else begin
      kind = 0; lat = 1; rw_e = rw;
    end
    $display("req kind=%0d addr=%h wdata=%h rd=%0b wr=%0b rw=%0b wreg=%0d", kind, a, wd, rd, wr, rw, wreg);
    chk("ready_before_transfer", 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_addr     = a;
    req_wdata    = wd;
    req_memread  = rd;
    req_memwrite = wr;
    req_regwrite = rw;
    req_wreg     = wreg;
    tick();
    for (int k = 1; k <= lat; k++) begin
      logic we_e;
      logic re_e;
      if (k < lat) begin
        // Inputs offered while busy must be ignored.
        req_valid    = 1'($urandom_range(0, 1));
        req_addr     = $urandom;
        req_wdata    = $urandom;
        req_memread  = 1'($urandom_range(0, 1));
        req_memwrite = 1'($urandom_range(0, 1));
        req_regwrite = 1'($urandom_range(0, 1));
        req_wreg     = 5'($urandom_range(0, 31));
      end else begin
        req_valid = 1'b0;
      end
      we_e = (kind == 2) && (k <= 4);
      re_e = (kind == 1) && (k <= 4);
      chk("mem_we", 32'(mem_we), 32'(we_e));
      chk("mem_re", 32'(mem_re), 32'(re_e));
      if (we_e || re_e) chk("mem_addr", mem_addr, a + 32'(k - 1));
      if (we_e) chk("mem_wdata", 32'(mem_wdata), 32'((wd >> (8 * (k - 1))) & 32'hFF));
      if (k < lat) begin
        chk("busy_wb_valid", 32'(wb_valid), 32'd0);
        chk("busy_err", 32'(err), 32'd0);
        chk("busy_ready", 32'(req_ready), 32'd0);
        tick();
      end else begin
        chk("wb_valid", 32'(wb_valid), 32'd1);
        chk("err", 32'(err), 32'(err_e));
        chk("wb_regwrite", 32'(wb_regwrite), 32'(rw_e));
        chk("wb_wreg", 32'(wb_wreg), 32'(wreg));
        if (kind <= 1) chk("wb_data", wb_data, data_e);
        chk("done_ready", 32'(req_ready), 32'd1);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  op;
    RESET_N      = 1'b0;
    fill         = 1'b1;
    req_valid    = 1'b0;
    req_addr     = 32'd0;
    req_wdata    = 32'd0;
    req_memread  = 1'b0;
    req_memwrite = 1'b0;
    req_regwrite = 1'b0;
    req_wreg     = 5'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    repeat (3) tick();

    // Reset state.
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_wreg", 32'(wb_wreg), 32'd0);
    chk("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
    chk("rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    fill    = 1'b0;
    RESET_N = 1'b1;
    idle(1);

    // Pass-through, store, load back.
    run_req(32'h0000000D, 32'd0, 1'b0, 1'b0, 1'b1, 5'd11);
    idle(1);
    run_req(32'h00000010, 32'h0000000C, 1'b0, 1'b1, 1'b1, 5'd3);
    idle(1);
    run_req(32'h00000010, 32'd0, 1'b1, 1'b0, 1'b1, 5'd7);
    chk("load_back_const", wb_data, 32'h0000000C);
    idle(1);

    // Misaligned load and illegal read+write.
    run_req(32'h00000012, 32'd0, 1'b1, 1'b0, 1'b1, 5'd9);
    idle(1);
    run_req(32'h00000010, 32'h55AA55AA, 1'b1, 1'b1, 1'b1, 5'd9);
    idle(1);

    // Back-to-back: each request issued during the previous DONE cycle.
    run_req(32'h00000020, 32'd0, 1'b1, 1'b0, 1'b1, 5'd21);
    run_req(32'h00000123, 32'd0, 1'b0, 1'b0, 1'b1, 5'd22);
    run_req(32'h00000024, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 5'd23);
    run_req(32'h00000024, 32'd0, 1'b1, 1'b0, 1'b1, 5'd24);
    idle(2);

    // Random traffic over a small window so loads see earlier stores.
    for (int t = 0; t < 40; t++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      op = 2'($urandom_range(0, 3));
      run_req(a, $urandom, op[0], op[1], 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      idle($urandom_range(0, 2));
    end
    idle(1);

    // Reset in the middle of a store: bytes 0 and 1 are already written.
    $display("req kind=store_reset addr=00000040 wdata=a1b2c3d4");
    req_valid    = 1'b1;
    req_addr     = 32'h00000040;
    req_wdata    = 32'hA1B2C3D4;
    req_memread  = 1'b0;
    req_memwrite = 1'b1;
    req_regwrite = 1'b1;
    req_wreg     = 5'd30;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("pre_reset_we", 32'(mem_we), 32'd1);
    chk("pre_reset_addr", mem_addr, 32'h00000042);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_strobes", {30'd0, mem_re, mem_we}, 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'd0);
    chk("mid_rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    chk("mid_rst_wb_data", wb_data, 32'd0);
    chk("mid_rst_wb_wreg", 32'(wb_wreg), 32'd0);
    chk("mid_rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
    ref_mem[8'h40] = 8'hD4;
    ref_mem[8'h41] = 8'hC3;
    tick();
    RESET_N = 1'b1;
    idle(1);
    run_req(32'h00000040, 32'd0, 1'b1, 1'b0, 1'b1, 5'd5);
    idle(1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
